// File: rtl/dmem_pkg.sv
// dmem_bridge shared constants: access sizes, FSM states, byte enables.
// The optional wait-state timeout is enabled by defining DMEM_TIMEOUT_EN.
package dmem_pkg;

  localparam logic [1:0] SEL_WORD = 2'b00;
  localparam logic [1:0] SEL_HALF = 2'b01;
  localparam logic [1:0] SEL_BYTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Little-endian lane steering: byte enables, store replication,
// misalignment detection and MSB-aligned load data.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_word,
  output logic        misalign,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shift;

  assign ld_shift = ld_word >> {off, 3'b000};

  always_comb begin
    be       = BE_ALL;
    st_word  = st_data;
    misalign = (off != 2'b00);
    ld_data  = ld_word;
    unique case (sel)
      SEL_HALF: begin
        be       = off[1] ? BE_HI : BE_LO;
        st_word  = {2{st_data[15:0]}};
        misalign = off[0];
        ld_data  = {ld_shift[15:0], 16'b0};
      end
      SEL_BYTE: begin
        be       = BE_B0 << off;
        st_word  = {4{st_data[7:0]}};
        misalign = 1'b0;
        ld_data  = {ld_shift[7:0], 24'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// CPU data-memory bridge: IDLE/BUSY/DONE req/ack sequencer with stall.
// Define DMEM_TIMEOUT_EN to bound BUSY at TIMEOUT_CYCLES wait states.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rena,
  input  logic              cpu_wena,
  input  logic [1:0]        cpu_select,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              stall,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_t            state_q, state_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        off_q, off_d;

  logic              idle, busy, done;
  logic [1:0]        f_sel, f_off;
  logic [3:0]        f_be;
  logic [31:0]       f_wd, f_rd;
  logic              f_mis;
  logic              tmo;

  assign idle = (state_q == S_IDLE);
  assign busy = (state_q == S_BUSY);
  assign done = (state_q == S_DONE);

  // IDLE steers the live request; BUSY reuses the latched size/offset for load data.
  assign f_sel = idle ? cpu_select    : sel_q;
  assign f_off = idle ? cpu_addr[1:0] : off_q;

  dmem_lane_fmt u_fmt (
    .sel      (f_sel),
    .off      (f_off),
    .st_data  (cpu_wdata),
    .ld_word  (mem_rdata),
    .be       (f_be),
    .st_word  (f_wd),
    .misalign (f_mis),
    .ld_data  (f_rd)
  );

`ifdef DMEM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  assign tmo = busy && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (busy) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    err_d   = err_q;
    sel_d   = sel_q;
    off_d   = off_q;
    unique case (state_q)
      S_IDLE: begin
        err_d = 1'b0;
        if (cpu_rena || cpu_wena) begin
          if (f_mis || (cpu_rena && cpu_wena)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            addr_d  = cpu_addr[ADDR_W-1:2];
            be_d    = cpu_wena ? f_be : BE_ALL;
            wdata_d = f_wd;
            we_d    = cpu_wena;
            sel_d   = cpu_select;
            off_d   = cpu_addr[1:0];
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = f_rd;
          state_d = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= BE_NONE;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= SEL_WORD;
      off_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      off_q   <= off_d;
    end
  end

  assign stall     = idle ? (cpu_rena | cpu_wena) : busy;
  assign err       = done & err_q;
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = rdata_q;

endmodule
